// File: rtl/chngy_pkg.sv
// chngy_pkg: shared definitions for the change-in-Y writeback stage.
// Holds the complex Y word layout, the default address width, the
// writeback FSM encoding and the FIFO entry packing helpers.
package chngy_pkg;

   // Complex Y word: upper half real, lower half imaginary.
   localparam int CY_DATA_W = 48;
   localparam int CY_REAL_W = 24;
   localparam int CY_IMAG_W = CY_DATA_W - CY_REAL_W;

   // Default Y-matrix memory address width.
   localparam int CY_ADDR_W = 10;

   // Writeback FSM: IDLE waits for data, ISSUE drives the memory write port.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } wb_state_t;

   // FIFO entry = {last, addr, data}; data sits at bit 0.
   localparam int ENT_DATA_LSB = 0;

   function automatic int entry_addr_lsb(input int data_w);
      return data_w;
   endfunction

   function automatic int entry_last_pos(input int addr_w, input int data_w);
      return addr_w + data_w;
   endfunction

   function automatic int entry_width(input int addr_w, input int data_w);
      return addr_w + data_w + 1;
   endfunction

endpackage

// File: rtl/chngy_wb_fifo.sv
// chngy_wb_fifo: synchronous FIFO for the writeback stage. Besides the usual
// head it also presents the entry behind the head so the writer can move on
// to the next write in the same cycle it retires the current one.
// almost_full is registered and tracks count >= DEPTH-1 with no extra lag.
module chngy_wb_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 59
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         head,
   output logic [WIDTH-1:0]         head_next,
   output logic                     full,
   output logic                     almost_full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_ptr_inc;
   logic             push_ok;
   logic             pop_ok;
   logic [CNT_W-1:0] count_next;

   assign full       = (count == FULL_CNT);
   assign empty      = (count == '0);
   assign pop_ok     = pop & ~empty;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign push_ok    = push & (~full | pop_ok);
   assign rd_ptr_inc = rd_ptr + PTR_W'(1);
   assign head       = mem[rd_ptr];
   assign head_next  = mem[rd_ptr_inc];

   // Occupancy after this edge's push/pop.
   always_comb begin
      count_next = count;
      if (push_ok && !pop_ok) begin
         count_next = count + CNT_W'(1);
      end else if (!push_ok && pop_ok) begin
         count_next = count - CNT_W'(1);
      end
   end

   // Pointers, occupancy and the registered almost-full flag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         almost_full <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr_inc;
         end
         count       <= count_next;
         almost_full <= (count_next >= AF_CNT);
      end
   end

   // Storage; entries are only read once counted, so no reset is needed.
   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem[wr_ptr] <= wdata;
      end
   end

endmodule

// File: rtl/chngy_writeback.sv
// chngy_writeback: captures change-in-Y results, buffers them and writes them
// verbatim to the Y-matrix memory. Handshake: a write transfers on every
// rising edge where mem_wr_en and mem_ready are both high; while mem_wr_en is
// high and mem_ready low, mem_addr/mem_wdata hold. in_valid has no ready and
// is pushed unconditionally; op_Stall asks the control path to stop issuing.
// Optional build macro CHNGY_WB_STATS_EN adds op_WrCount / op_GroupCount.
module chngy_writeback
   import chngy_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = CY_ADDR_W,
   parameter int DATA_W = CY_DATA_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   input  logic              in_last,
   input  logic [DATA_W-1:0] in_data,
   input  logic [ADDR_W-1:0] in_addr,
   output logic              op_Stall,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   output logic              op_GroupDone,
   output logic              op_Overflow,
   output logic              op_Busy,
   output wb_state_t         fsm_state
`ifdef CHNGY_WB_STATS_EN
   ,
   output logic [15:0]       op_WrCount,
   output logic [15:0]       op_GroupCount
`endif
);

   localparam int CNT_W    = $clog2(DEPTH) + 1;
   localparam int ENT_W    = entry_width(ADDR_W, DATA_W);
   localparam int LAST_POS = entry_last_pos(ADDR_W, DATA_W);
   localparam int ADDR_LSB = entry_addr_lsb(DATA_W);

   wb_state_t        state;
   logic [ENT_W-1:0] in_entry;
   logic [ENT_W-1:0] head;
   logic [ENT_W-1:0] head_next;
   logic [ENT_W-1:0] load_entry;
   logic             full;
   logic             almost_full;
   logic             empty;
   logic [CNT_W-1:0] count;
   logic             accept;
   logic             push_taken;
   logic             drop;
   logic             cur_last;

   assign in_entry   = {in_last, in_addr, in_data};
   assign accept     = mem_wr_en & mem_ready;
   assign push_taken = in_valid & (~full | accept);
   assign drop       = in_valid & full & ~accept;
   assign op_Stall   = almost_full;
   assign op_Busy    = (count != '0) | mem_wr_en;
   assign fsm_state  = state;

   chngy_wb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
   ) u_fifo (
      .clock       (clock),
      .reset       (reset),
      .push        (in_valid),
      .pop         (accept),
      .wdata       (in_entry),
      .head        (head),
      .head_next   (head_next),
      .full        (full),
      .almost_full (almost_full),
      .empty       (empty),
      .count       (count)
   );

   // Next entry to present: the head when starting from IDLE; when retiring
   // the head, the one behind it, or the entry arriving this very cycle if
   // the FIFO only held the head.
   always_comb begin
      load_entry = head;
      if (state == ST_ISSUE) begin
         load_entry = (count > CNT_W'(1)) ? head_next : in_entry;
      end
   end

   // Writeback FSM with registered memory port and status flags.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         mem_wr_en    <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         cur_last     <= 1'b0;
         op_GroupDone <= 1'b0;
         op_Overflow  <= 1'b0;
      end else begin
         op_GroupDone <= accept & cur_last;
         if (drop) begin
            op_Overflow <= 1'b1;
         end
         case (state)
            ST_IDLE: begin
               if (!empty) begin
                  state     <= ST_ISSUE;
                  mem_wr_en <= 1'b1;
                  cur_last  <= load_entry[LAST_POS];
                  mem_addr  <= load_entry[ADDR_LSB +: ADDR_W];
                  mem_wdata <= load_entry[DATA_W-1:0];
               end
            end
            ST_ISSUE: begin
               if (mem_ready) begin
                  if ((count > CNT_W'(1)) || push_taken) begin
                     cur_last  <= load_entry[LAST_POS];
                     mem_addr  <= load_entry[ADDR_LSB +: ADDR_W];
                     mem_wdata <= load_entry[DATA_W-1:0];
                  end else begin
                     state     <= ST_IDLE;
                     mem_wr_en <= 1'b0;
                     cur_last  <= 1'b0;
                  end
               end
            end
            default: begin
               state     <= ST_IDLE;
               mem_wr_en <= 1'b0;
            end
         endcase
      end
   end

`ifdef CHNGY_WB_STATS_EN
   // Accepted-write and group-completion counters; both wrap at 16 bits.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         op_WrCount    <= '0;
         op_GroupCount <= '0;
      end else begin
         if (accept) begin
            op_WrCount <= op_WrCount + 16'd1;
         end
         if (accept && cur_last) begin
            op_GroupCount <= op_GroupCount + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_chngy_writeback.sv
// tb_chngy_writeback: self-checking bench for chngy_writeback.
// A queue-based model of the buffered writer is compared every cycle;
// directed sections pin latency, ordering, back-pressure and reset.
module tb_chngy_writeback;

   localparam int DEPTH = 4;
   localparam int AW    = 10;
   localparam int DW    = 48;
   localparam int EW    = AW + DW + 1;

   logic          clock;
   logic          reset;
   logic          in_valid;
   logic          in_last;
   logic [DW-1:0] in_data;
   logic [AW-1:0] in_addr;
   logic          op_Stall;
   logic          mem_wr_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ready;
   logic          op_GroupDone;
   logic          op_Overflow;
   logic          op_Busy;
   chngy_pkg::wb_state_t fsm_state;
`ifdef CHNGY_WB_STATS_EN
   logic [15:0]   op_WrCount;
   logic [15:0]   op_GroupCount;
`endif

   chngy_writeback #(
      .DEPTH  (DEPTH),
      .ADDR_W (AW),
      .DATA_W (DW)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_last      (in_last),
      .in_data      (in_data),
      .in_addr      (in_addr),
      .op_Stall     (op_Stall),
      .mem_wr_en    (mem_wr_en),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ready    (mem_ready),
      .op_GroupDone (op_GroupDone),
      .op_Overflow  (op_Overflow),
      .op_Busy      (op_Busy),
      .fsm_state    (fsm_state)
`ifdef CHNGY_WB_STATS_EN
      ,
      .op_WrCount    (op_WrCount),
      .op_GroupCount (op_GroupCount)
`endif
   );

   // ---------------- clock ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- counters and check ----------------
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // exp_q holds every entry not yet accepted by memory, oldest first; while
   // a write is outstanding its head is what must be on the write port.
   logic [EW-1:0] exp_q[$];
   logic          m_wr;
   logic          m_gd;
   logic          m_ovf;
   logic          m_stall;
   logic [15:0]   m_wrc;
   logic [15:0]   m_grc;
   int            m_n0;
   logic          m_acc;
   logic [EW-1:0] m_e;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         exp_q.delete();
         m_wr    = 1'b0;
         m_gd    = 1'b0;
         m_ovf   = 1'b0;
         m_stall = 1'b0;
         m_wrc   = '0;
         m_grc   = '0;
      end else begin
         m_n0  = exp_q.size();
         m_acc = m_wr && mem_ready;
         m_gd  = 1'b0;
         if (m_acc) begin
            m_e   = exp_q.pop_front();
            m_gd  = m_e[EW-1];
            m_wrc = m_wrc + 16'd1;
            if (m_e[EW-1]) m_grc = m_grc + 16'd1;
         end
         if (in_valid) begin
            if (m_n0 < DEPTH || m_acc) exp_q.push_back({in_last, in_addr, in_data});
            else m_ovf = 1'b1;
         end
         if (m_wr) m_wr = m_acc ? (exp_q.size() != 0) : 1'b1;
         else      m_wr = (m_n0 != 0);
         m_stall = (exp_q.size() >= DEPTH - 1);
      end
   end

   // ---------------- per-cycle compare ----------------
   logic [EW-1:0] c_h;
   always @(negedge clock) begin
      if (reset) begin
         check("mem_wr_en", mem_wr_en, m_wr);
         check("fsm_issue", fsm_state == chngy_pkg::ST_ISSUE, m_wr);
         if (m_wr) begin
            c_h = exp_q[0];
            check("mem_addr", mem_addr, c_h[DW +: AW]);
            check("mem_wdata", mem_wdata, c_h[DW-1:0]);
         end
         check("op_GroupDone", op_GroupDone, m_gd);
         check("op_Overflow", op_Overflow, m_ovf);
         check("op_Stall", op_Stall, m_stall);
         check("op_Busy", op_Busy, (exp_q.size() != 0) || m_wr);
`ifdef CHNGY_WB_STATS_EN
         check("op_WrCount", op_WrCount, m_wrc);
         check("op_GroupCount", op_GroupCount, m_grc);
`endif
      end
   end

   // ---------------- write log (actual writes seen on the port) ----------------
   logic [AW+DW-1:0] wlog[$];
   int gd_cnt;
   always @(negedge clock) begin
      if (reset && mem_wr_en && mem_ready) wlog.push_back({mem_addr, mem_wdata});
      if (reset && op_GroupDone) gd_cnt++;
   end

   // ---------------- driver ----------------
   task automatic step(input logic v, input logic l, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic r);
      in_valid  = v;
      in_last   = l;
      in_addr   = a;
      in_data   = d;
      mem_ready = r;
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n, input logic r);
      repeat (n) step(1'b0, 1'b0, '0, '0, r);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // ---------------- stimulus ----------------
   logic [AW+DW-1:0] push_log[$];
   logic [AW+DW-1:0] w;
   logic [AW+DW-1:0] held;
   logic [63:0]      r64;
   logic [AW-1:0]    ra;
   logic [DW-1:0]    rd;
   logic [AW-1:0]    bp_a[5];
   logic [DW-1:0]    bp_d[5];
   logic [AW-1:0]    pair_a[3];

   initial begin
      reset = 1'b0;
      in_valid = 1'b0; in_last = 1'b0; in_addr = '0; in_data = '0; mem_ready = 1'b0;
      gd_cnt = 0;
      repeat (3) @(posedge clock);
      #1;
      // Reset state
      check("rst_wr_en", mem_wr_en, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_gd", op_GroupDone, 0);
      check("rst_ovf", op_Overflow, 0);
      check("rst_stall", op_Stall, 0);
      check("rst_busy", op_Busy, 0);
      reset = 1'b1;
      idle(2, 1'b1);

      // Single diagonal result: 2-cycle latency, one write, GroupDone after.
      wlog.delete(); gd_cnt = 0;
      step(1'b1, 1'b1, 10'h005, 48'h000100_FFFF00, 1'b1);
      check("t1_lat1_wr_en", mem_wr_en, 0);
      idle(1, 1'b1);
      check("t1_wr_en", mem_wr_en, 1);
      check("t1_addr", mem_addr, 10'h005);
      check("t1_wdata", mem_wdata, 48'h000100_FFFF00);
      check("t1_gd_early", op_GroupDone, 0);
      idle(1, 1'b1);
      check("t1_wr_en_drop", mem_wr_en, 0);
      check("t1_gd", op_GroupDone, 1);
      idle(1, 1'b1);
      check("t1_gd_pulse", op_GroupDone, 0);
      check("t1_busy", op_Busy, 0);

      // Pair plus diagonal
      wlog.delete(); gd_cnt = 0;
      pair_a = '{10'h012, 10'h021, 10'h011};
      step(1'b1, 1'b0, pair_a[0], 48'h000001_000010, 1'b1);
      step(1'b1, 1'b0, pair_a[1], 48'h000002_000020, 1'b1);
      step(1'b1, 1'b1, pair_a[2], 48'h000003_000030, 1'b1);
      idle(6, 1'b1);
      check("t2_writes", wlog.size(), 3);
      for (int i = 0; i < 3 && i < wlog.size(); i++) begin
         w = wlog[i];
         check("t2_order", w[DW +: AW], pair_a[i]);
      end
      check("t2_groupdone", gd_cnt, 1);

      // Handshake hold
      wlog.delete();
      step(1'b1, 1'b0, 10'h155, 48'hABCDEF_123456, 1'b0);
      idle(1, 1'b0);
      check("t3_wr_en", mem_wr_en, 1);
      repeat (5) begin
         idle(1, 1'b0);
         check("t3_hold_addr", mem_addr, 10'h155);
         check("t3_hold_data", mem_wdata, 48'hABCDEF_123456);
      end
      idle(1, 1'b1);
      check("t3_done", mem_wr_en, 0);
      check("t3_writes", wlog.size(), 1);
      held = {10'h155, 48'hABCDEF_123456};
      if (wlog.size() > 0) check("t3_entry", wlog[0], held);

      // Wrap-around with zero data
      wlog.delete(); push_log.delete();
      for (int i = 0; i < 10; i++) begin
         r64 = {$urandom(), $urandom()};
         ra  = 10'($urandom_range(0, 1023));
         rd  = (i % 3 == 0) ? '0 : r64[DW-1:0];
         push_log.push_back({ra, rd});
         step(1'b1, (i == 9), ra, rd, 1'b1);
         idle($urandom_range(0, 2), 1'b1);
      end
      idle(6, 1'b1);
      check("t4_writes", wlog.size(), 10);
      for (int i = 0; i < 10 && i < wlog.size(); i++) check("t4_order", wlog[i], push_log[i]);

      // Back-pressure and overflow
      wlog.delete();
      bp_a = '{10'h101, 10'h102, 10'h103, 10'h104, 10'h105};
      bp_d = '{48'h111111_000001, 48'h0, 48'h333333_000003, 48'h444444_000004, 48'h555555_000005};
      step(1'b1, 1'b0, bp_a[0], bp_d[0], 1'b0);
      step(1'b1, 1'b0, bp_a[1], bp_d[1], 1'b0);
      check("t5_stall_2", op_Stall, 0);
      step(1'b1, 1'b0, bp_a[2], bp_d[2], 1'b0);
      check("t5_stall_3", op_Stall, 1);
      step(1'b1, 1'b0, bp_a[3], bp_d[3], 1'b0);
      check("t5_ovf_4", op_Overflow, 0);
      check("t5_stall_4", op_Stall, 1);
      step(1'b1, 1'b1, bp_a[4], bp_d[4], 1'b0);
      check("t5_ovf_5", op_Overflow, 1);
      idle(8, 1'b1);
      check("t5_writes", wlog.size(), 4);
      for (int i = 0; i < 4 && i < wlog.size(); i++) check("t5_order", wlog[i], {bp_a[i], bp_d[i]});
      check("t5_ovf_sticky", op_Overflow, 1);

      // Randomised traffic against the model
      for (int i = 0; i < 600; i++) begin
         r64 = {$urandom(), $urandom()};
         rd  = ($urandom_range(0, 7) == 0) ? '0 : r64[DW-1:0];
         step($urandom_range(0, 99) < 60, $urandom_range(0, 3) == 0,
              10'($urandom_range(0, 1023)), rd, $urandom_range(0, 99) < 55);
      end
      idle(10, 1'b1);

      // Mid-write reset
      step(1'b1, 1'b0, 10'h3A5, 48'h5A5A5A_A5A5A5, 1'b0);
      idle(1, 1'b0);
      check("t7_wr_en", mem_wr_en, 1);
      #2;
      reset = 1'b0;
      #1;
      check("t7_rst_wr_en", mem_wr_en, 0);
      check("t7_rst_busy", op_Busy, 0);
      check("t7_rst_addr", mem_addr, 0);
      check("t7_rst_wdata", mem_wdata, 0);
      check("t7_rst_ovf", op_Overflow, 0);
      check("t7_rst_stall", op_Stall, 0);
`ifdef CHNGY_WB_STATS_EN
      check("t7_rst_wrcount", op_WrCount, 0);
      check("t7_rst_grpcount", op_GroupCount, 0);
`endif
      @(posedge clock);
      #1;
      reset = 1'b1;
      wlog.delete();
      step(1'b1, 1'b1, 10'h0C3, 48'h0, 1'b1);
      idle(4, 1'b1);
      check("t7_writes", wlog.size(), 1);
      held = {10'h0C3, 48'h0};
      if (wlog.size() > 0) check("t7_entry", wlog[0], held);

      idle(3, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/chngy_writeback.md
Name: chngy_writeback

Overview:
- Downstream stage of the change-in-Y update datapath.
- Captures each computed 48-bit complex Y value (valid when the datapath's execute-done flag is high), tagged with its target matrix address and a group-last flag (the datapath's done flag).
- Buffers results in a small FIFO and writes them to the Y-matrix memory over a valid/ready write port.
- Back-pressures the control path and pulses when a whole change record (off-diagonal pair plus diagonal) has been committed.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
ADDR_W, 10, Y-matrix memory address width
DATA_W, 48, complex Y word (upper 24 bits real, lower 24 bits imaginary)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  result valid (datapath execute-done flag)
in_last  in  1  last result of the change record (datapath done flag)
in_data  in  DATA_W  computed Y value
in_addr  in  ADDR_W  target Y-matrix address, aligned with in_data
op_Stall  out  1  registered almost-full; control path drops execute enable while high
mem_wr_en  out  1  memory write request
mem_addr  out  ADDR_W  write address
mem_wdata  out  DATA_W  write data
mem_ready  in  1  memory accepts the write this cycle when high together with mem_wr_en
op_GroupDone  out  1  one-cycle pulse: the last-tagged entry was accepted by memory
op_Overflow  out  1  sticky: a push was dropped because the FIFO was full
op_Busy  out  1  FIFO non-empty or a write is outstanding

Behaviour:
- Reset (async, reset=0): all outputs 0; FIFO pointers and count 0; FSM in IDLE.
- FIFO entry = {last, addr, data}. Push on every clock edge where in_valid=1.
- Full FIFO, no pop in the same cycle: the push is dropped and op_Overflow is set. It clears only on reset.
- Full FIFO, pop in the same cycle: the push is accepted.
- op_Stall is registered, high when count >= DEPTH-1. One cycle of in-flight result is therefore always absorbed.
- FSM states:
  - IDLE: mem_wr_en=0. If the FIFO is non-empty, go to ISSUE and load the head entry into the output registers. Minimum latency from push into an empty FIFO to mem_wr_en high is 2 cycles.
  - ISSUE: mem_wr_en=1; mem_addr and mem_wdata are held stable until mem_ready=1.
  - On acceptance, pop the head. If the accepted entry had last=1, pulse op_GroupDone on the next cycle.
  - If the FIFO is still non-empty after the pop, stay in ISSUE with the next head loaded. This gives back-to-back writes with no bubble.
  - Otherwise return to IDLE.
- Pointers wrap modulo DEPTH; count width is log2(DEPTH)+1.
- No arithmetic on data; values are written verbatim, including all-zero values (zero is a legitimate Y entry).
- op_Busy = (count != 0) | mem_wr_en.
- If reset is asserted mid-write, the outstanding write is abandoned: mem_wr_en drops asynchronously and the FIFO contents are lost.

Optional Feature:
CHNGY_WB_STATS_EN
- Defined: adds outputs op_WrCount (16 bits, accepted writes) and op_GroupCount (16 bits, op_GroupDone pulses). Both wrap at 0xFFFF->0 and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package chngy_pkg:
  - DATA_W=48 and its REAL_W/IMAG_W split
  - ADDR_W default
  - FSM state encoding (IDLE=0, ISSUE=1)
  - FIFO entry packing offsets
- One sub-module, chngy_wb_fifo: a synchronous FIFO with push/pop/full/almost_full/empty/count.
- The FSM, the memory handshake and the flags live in the top level.

Test Plan:
- Single diagonal result: in_valid=1, in_last=1, addr=0x005, data=0x000100_FFFF00, mem_ready=1 -> mem_wr_en high 2 cycles later with the same addr and data for 1 cycle; op_GroupDone pulses the next cycle.
- Pair-plus-diagonal: three consecutive pushes (addr 0x012, 0x021, 0x011; last only on the third), mem_ready=1 -> three back-to-back writes in order; exactly one op_GroupDone, after the 0x011 write.
- Back-pressure: mem_ready=0, push 3 entries -> op_Stall high after the count reaches 3. A 4th push is accepted (count=4). A 5th push sets op_Overflow=1 and leaves count=4. Releasing mem_ready drains 4 writes in order.
- Handshake hold: mem_ready low for 5 cycles during ISSUE -> mem_addr and mem_wdata unchanged throughout; the write completes on the first ready cycle.
- Wrap-around: 10 pushes interleaved with drains (DEPTH=4) -> write order matches push order, including zero-data entries.
- Mid-write reset: assert reset while mem_wr_en=1 -> outputs 0 immediately, op_Busy=0. After release, a new push is written normally. With CHNGY_WB_STATS_EN defined, the counters read 0 after the reset.
